// File: rtl/lifo_access_arbiter.sv
// lifo_access_arbiter
//   Arbitrates two requesters onto a single LIFO stack. Each granted request
//   becomes exactly one push or pop on the LIFO. The requester receives a
//   one-cycle ack. The ack carries pop data, or an error flag when the
//   request was a push while full or a pop while empty.
//   Grants alternate round-robin when both clients request. Client 0 wins
//   first after reset. This block is the only driver of the LIFO strobes and
//   data_in.
//
// Parameters
//   DW      data width (LIFO word)
//   PW      width of the LIFO pointer input
//   RD_LAT  cycles from lifo_rd until lifo_dout is valid (1..7)
//
// Ports
//   clk, rst_n            clock (rising edge), async active-low reset
//   req0/req1             client requests, held until ack
//   op0/op1               1 = push, 0 = pop
//   wdata0/wdata1         push data
//   ack0/ack1             one-cycle completion pulses
//   rsp_err, rsp_data     response qualifiers, valid with ack
//   lifo_wr, lifo_rd      one-cycle LIFO strobes
//   lifo_din              LIFO data_in
//   lifo_dout             LIFO data_out
//   lifo_full, lifo_empty LIFO status flags
//   lifo_ptr              LIFO pointer (statistics only)
//   busy                  high whenever the FSM is not idle
//
// Optional feature (macro LIFO_ARB_STATS_EN)
//   Adds the outputs stat_push, stat_pop and stat_err. These are saturating
//   16-bit counters. It also adds stat_max_ptr, the high-water mark of
//   lifo_ptr.

module lifo_access_arbiter #(
  parameter int unsigned DW     = 32,
  parameter int unsigned PW     = 10,
  parameter int unsigned RD_LAT = 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          req0,
  input  logic          req1,
  input  logic          op0,
  input  logic          op1,
  input  logic [DW-1:0] wdata0,
  input  logic [DW-1:0] wdata1,
  output logic          ack0,
  output logic          ack1,
  output logic          rsp_err,
  output logic [DW-1:0] rsp_data,
  output logic          lifo_wr,
  output logic          lifo_rd,
  output logic [DW-1:0] lifo_din,
  input  logic [DW-1:0] lifo_dout,
  input  logic          lifo_full,
  input  logic          lifo_empty,
  input  logic [PW-1:0] lifo_ptr,
  output logic          busy
`ifdef LIFO_ARB_STATS_EN
  ,
  output logic [15:0]   stat_push,
  output logic [15:0]   stat_pop,
  output logic [15:0]   stat_err,
  output logic [PW-1:0] stat_max_ptr
`endif
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  localparam logic [2:0] LAT_LAST = 3'(RD_LAT - 1);

  state_t     state;
  logic       gnt;         // client owning the current transaction
  logic       last_grant;  // client served most recently
  logic       op_q;        // latched operation, 1 = push
  logic       err_q;       // latched legality verdict
  logic [2:0] wait_cnt;

  // Arbitration: a lone requester wins outright; on a tie the client
  // that was not served last wins.
  logic          grant_c;
  logic          sel_op;
  logic [DW-1:0] sel_wdata;

  always_comb begin
    grant_c = ~last_grant;
    if (req0 && !req1) begin
      grant_c = 1'b0;
    end else if (req1 && !req0) begin
      grant_c = 1'b1;
    end
  end

  assign sel_op    = grant_c ? op1    : op0;
  assign sel_wdata = grant_c ? wdata1 : wdata0;

  // The strobes and lifo_din are registered. They are therefore loaded on
  // the transition into ISSUE, and are high exactly for the ISSUE cycle.
  // The full/empty flags are sampled on that same edge. The flags cannot
  // change in between, because nothing else drives the LIFO.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      gnt        <= 1'b0;
      last_grant <= 1'b1;
      op_q       <= 1'b0;
      err_q      <= 1'b0;
      wait_cnt   <= '0;
      ack0       <= 1'b0;
      ack1       <= 1'b0;
      rsp_err    <= 1'b0;
      rsp_data   <= '0;
      lifo_wr    <= 1'b0;
      lifo_rd    <= 1'b0;
      lifo_din   <= '0;
      busy       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req0 || req1) begin
            gnt   <= grant_c;
            op_q  <= sel_op;
            busy  <= 1'b1;
            state <= ISSUE;
            if (sel_op) begin
              err_q    <= lifo_full;
              lifo_wr  <= ~lifo_full;
              lifo_din <= lifo_full ? '0 : sel_wdata;
            end else begin
              err_q    <= lifo_empty;
              lifo_rd  <= ~lifo_empty;
            end
          end
        end

        ISSUE: begin
          lifo_wr  <= 1'b0;
          lifo_rd  <= 1'b0;
          lifo_din <= '0;
          wait_cnt <= '0;
          if (!op_q && !err_q) begin
            state <= WAIT;
          end else begin
            ack0    <= ~gnt;
            ack1    <= gnt;
            rsp_err <= err_q;
            state   <= RESP;
          end
        end

        WAIT: begin
          if (wait_cnt == LAT_LAST) begin
            rsp_data <= lifo_dout;
            ack0     <= ~gnt;
            ack1     <= gnt;
            state    <= RESP;
          end else begin
            wait_cnt <= wait_cnt + 3'd1;
          end
        end

        RESP: begin
          ack0       <= 1'b0;
          ack1       <= 1'b0;
          rsp_err    <= 1'b0;
          rsp_data   <= '0;
          busy       <= 1'b0;
          last_grant <= gnt;
          state      <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

`ifdef LIFO_ARB_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_push    <= '0;
      stat_pop     <= '0;
      stat_err     <= '0;
      stat_max_ptr <= '0;
    end else begin
      if (lifo_wr && stat_push != 16'hFFFF) begin
        stat_push <= stat_push + 16'd1;
      end
      if (lifo_rd && stat_pop != 16'hFFFF) begin
        stat_pop <= stat_pop + 16'd1;
      end
      if (state == ISSUE && err_q && stat_err != 16'hFFFF) begin
        stat_err <= stat_err + 16'd1;
      end
      if (lifo_ptr > stat_max_ptr) begin
        stat_max_ptr <= lifo_ptr;
      end
    end
  end
`else
  logic unused_ptr;
  assign unused_ptr = ^lifo_ptr;
`endif

endmodule

// File: tb/tb_lifo_access_arbiter.sv
module tb_lifo_access_arbiter;

  localparam int DW     = 32;
  localparam int PW     = 4;
  localparam int RD_LAT = 1;
  localparam int DEPTH  = 8;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          req0, req1, op0, op1;
  logic [DW-1:0] wdata0, wdata1;
  logic          ack0, ack1, rsp_err;
  logic [DW-1:0] rsp_data;
  logic          lifo_wr, lifo_rd;
  logic [DW-1:0] lifo_din, lifo_dout;
  logic          lifo_full, lifo_empty;
  logic [PW-1:0] lifo_ptr;
  logic          busy;
`ifdef LIFO_ARB_STATS_EN
  logic [15:0]   stat_push, stat_pop, stat_err;
  logic [PW-1:0] stat_max_ptr;
`endif

  lifo_access_arbiter #(.DW(DW), .PW(PW), .RD_LAT(RD_LAT)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0(req0), .req1(req1), .op0(op0), .op1(op1),
    .wdata0(wdata0), .wdata1(wdata1),
    .ack0(ack0), .ack1(ack1), .rsp_err(rsp_err), .rsp_data(rsp_data),
    .lifo_wr(lifo_wr), .lifo_rd(lifo_rd), .lifo_din(lifo_din),
    .lifo_dout(lifo_dout), .lifo_full(lifo_full), .lifo_empty(lifo_empty),
    .lifo_ptr(lifo_ptr), .busy(busy)
`ifdef LIFO_ARB_STATS_EN
    , .stat_push(stat_push), .stat_pop(stat_pop), .stat_err(stat_err),
    .stat_max_ptr(stat_max_ptr)
`endif
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural LIFO with a one-cycle read latency
  logic [DW-1:0] mem [DEPTH];
  logic [PW-1:0] mptr;
  assign lifo_full  = (mptr == PW'(DEPTH));
  assign lifo_empty = (mptr == '0);
  assign lifo_ptr   = mptr;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mptr      <= '0;
      lifo_dout <= '0;
    end else if (lifo_wr && !lifo_full) begin
      mem[mptr[2:0]] <= lifo_din;
      mptr           <= mptr + 1'b1;
    end else if (lifo_rd && !lifo_empty) begin
      lifo_dout <= mem[3'(mptr - 1'b1)];
      mptr      <= mptr - 1'b1;
    end
  end

  int vectors = 0;
  int miscompares = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  typedef struct {
    int          c;
    logic        err;
    logic [31:0] data;
    int          at;
  } exp_t;
  exp_t sb[$];

  // Response monitor: every ack is matched against the oldest expectation
  always @(negedge clk) begin
    if (rst_n) begin
      check("strobe_excl", 32'(lifo_wr & lifo_rd), 0);
      check("strobe_busy", 32'((lifo_wr | lifo_rd) & ~busy), 0);
      check("ack_excl", 32'(ack0 & ack1), 0);
      if (ack0 || ack1) begin
        if (sb.size() == 0) begin
          check("unexpected_ack", 32'(ack0 | ack1), 0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          check("ack_client", 32'(ack1), 32'(e.c));
          check("rsp_err", 32'(rsp_err), 32'(e.err));
          check("rsp_data", rsp_data, e.data);
          check("ack_cycle", 32'(cyc), 32'(e.at));
        end
      end else begin
        check("rsp_err_idle", 32'(rsp_err), 0);
        check("rsp_data_idle", rsp_data, 0);
      end
    end
  end

  task automatic set_req(input int c, input logic r, input logic o, input logic [DW-1:0] d);
    if (c == 0) begin
      req0 = r; op0 = o; wdata0 = d;
    end else begin
      req1 = r; op1 = o; wdata1 = d;
    end
  endtask

  task automatic wait_ack(input int c);
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if ((c == 0) ? ack0 : ack1) return;
    end
    check("ack_timeout", 0, 1);
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_ack0"}, 32'(ack0), 0);
    check({tag, "_ack1"}, 32'(ack1), 0);
    check({tag, "_err"}, 32'(rsp_err), 0);
    check({tag, "_data"}, rsp_data, 0);
    check({tag, "_wr"}, 32'(lifo_wr), 0);
    check({tag, "_rd"}, 32'(lifo_rd), 0);
    check({tag, "_din"}, lifo_din, 0);
    check({tag, "_busy"}, 32'(busy), 0);
  endtask

  // Assert reset at once and hold it for two cycles
  task automatic do_reset(input string tag);
    rst_n = 1'b0;
    set_req(0, 0, 0, '0);
    set_req(1, 0, 0, '0);
    #1;
    check_outputs_zero(tag);
    repeat (2) begin
      @(negedge clk);
      check({tag, "_no_ack"}, 32'(ack0 | ack1), 0);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  // One transaction from a single client, checked end to end
  task automatic run_op(input int c, input logic op, input logic [DW-1:0] d,
                        input logic exp_err, input logic [DW-1:0] exp_data);
    int n;
    exp_t e;
    @(posedge clk); #1;
    n = cyc;
    set_req(c, 1'b1, op, d);
    e.c = c; e.err = exp_err; e.data = exp_data;
    e.at = n + 2 + ((!op && !exp_err) ? RD_LAT : 0);
    sb.push_back(e);
    @(negedge clk);
    @(negedge clk);
    check("wr_strobe", 32'(lifo_wr), 32'(op && !exp_err));
    check("rd_strobe", 32'(lifo_rd), 32'(!op && !exp_err));
    if (op && !exp_err) check("lifo_din", lifo_din, d);
    wait_ack(c);
    @(posedge clk); #1;
    set_req(c, 1'b0, 1'b0, '0);
  endtask

  // Client holding req high across several back-to-back pushes
  task automatic client_seq(input int c, input int nops);
    for (int k = 0; k < nops; k++) begin
      set_req(c, 1'b1, 1'b1, 32'hC000_0000 | (c << 8) | k);
      wait_ack(c);
      @(posedge clk); #1;
    end
    set_req(c, 1'b0, 1'b0, '0);
  endtask

  initial begin
    int n;
    rst_n = 1'b0;
    set_req(0, 0, 0, '0);
    set_req(1, 0, 0, '0);
    @(negedge clk);
    do_reset("reset");

    // Reset abandons a pop caught in WAIT
    run_op(0, 1'b1, 32'h1234_5678, 1'b0, '0);
    @(posedge clk); #1;
    set_req(0, 1'b1, 1'b0, '0);
    @(negedge clk);
    @(negedge clk);
    check("midpop_rd", 32'(lifo_rd), 1);
    @(negedge clk);
    check("midpop_busy", 32'(busy), 1);
    do_reset("midpop");
    run_op(0, 1'b0, '0, 1'b1, '0);

    // Two pushes, then two pops in reverse order
    run_op(0, 1'b1, 32'h8000_0000, 1'b0, '0);
    run_op(0, 1'b1, 32'h4000_0000, 1'b0, '0);
    run_op(1, 1'b0, '0, 1'b0, 32'h4000_0000);
    run_op(1, 1'b0, '0, 1'b0, 32'h8000_0000);

    // Pop while empty
    run_op(0, 1'b0, '0, 1'b1, '0);

    // Both clients contend: grants alternate 0,1,0,1... every three cycles
    @(negedge clk);
    do_reset("rst2");
    @(posedge clk); #1;
    n = cyc;
    for (int k = 0; k < 8; k++) begin
      exp_t e;
      e.c = k % 2; e.err = 1'b0; e.data = '0; e.at = n + 2 + 3 * k;
      sb.push_back(e);
    end
    fork
      client_seq(0, 4);
      client_seq(1, 4);
    join
    repeat (2) @(negedge clk);
    check("ptr_after_8", 32'(lifo_ptr), 8);
`ifdef LIFO_ARB_STATS_EN
    check("stat_push_8", 32'(stat_push), 8);
    check("stat_max_ptr_8", 32'(stat_max_ptr), 8);
`endif

    // Push while full leaves the stack alone
    run_op(1, 1'b1, 32'hDEAD_BEEF, 1'b1, '0);
    @(negedge clk);
    check("ptr_after_full_push", 32'(lifo_ptr), 8);
    run_op(0, 1'b0, '0, 1'b0, 32'hC000_0103);
    run_op(0, 1'b0, '0, 1'b0, 32'hC000_0003);
`ifdef LIFO_ARB_STATS_EN
    @(negedge clk);
    check("stat_push_end", 32'(stat_push), 8);
    check("stat_pop_end", 32'(stat_pop), 2);
    check("stat_err_end", 32'(stat_err), 1);
`endif

    repeat (3) @(negedge clk);
    check("sb_drained", 32'(sb.size()), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
